// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for stream-fed memory loaders.
// Contents:
//   loader_state_t  - loader state encoding (IDLE, COUNT, DATA, RUN)
//   bytes_per_word  - number of stream bytes needed to carry one memory word
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DATA  = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_t;

  // ceil(width_bits / 8): whole bytes needed to hold one word
  function automatic int bytes_per_word(input int width_bits);
    return (width_bits + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/prog_loader_instr_mem.sv
// prog_loader_instr_mem
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are not reset.
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (fetch)
//   rdata  out  mem[raddr], combinational
module prog_loader_instr_mem #(
  parameter int INS_WIDTH     = 12,
  parameter int INSADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [INSADDR_WIDTH-1:0] waddr,
  input  logic [INS_WIDTH-1:0]     wdata,
  input  logic [INSADDR_WIDTH-1:0] raddr,
  output logic [INS_WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << INSADDR_WIDTH;

  logic [INS_WIDTH-1:0] mem_r [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // The core decodes in its fetch cycle, so the read has zero latency
  assign rdata = mem_r[raddr];

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Fills the instruction memory from a byte stream and holds the core in reset
// while doing so. Stream format: one count byte (0 means full depth, values
// above depth are clamped), then big-endian words of BYTES_PER_INS bytes.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   load_start    in   one-cycle request to begin a load (honoured in IDLE/RUN)
//   s_data        in   stream byte
//   s_valid       in   s_data valid
//   s_ready       out  loader accepts a byte on s_valid & s_ready
//   instr_addr    in   fetch address from the core PC
//   instr         out  instruction at instr_addr, same cycle
//   cpu_rst       out  active-high reset to the core
//   busy          out  load in progress
//   load_done     out  one-cycle pulse on the first RUN cycle
//   loaded_count  out  words written by the last completed load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INS_WIDTH     = 12,
  parameter int INSADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [INSADDR_WIDTH-1:0] instr_addr,
  output logic [INS_WIDTH-1:0]     instr,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     load_done,
  output logic [INSADDR_WIDTH:0]   loaded_count
);

  localparam int BYTES_PER_INS = bytes_per_word(INS_WIDTH);
  localparam int BCNT_W        = $clog2(BYTES_PER_INS + 1);
  localparam int ASM_W         = 8 * BYTES_PER_INS;
  localparam int CNT_W         = INSADDR_WIDTH + 1;
  // Count arithmetic is done in 9 bits so a full byte can be compared to depth
  localparam logic [8:0] DEPTH_9 = 9'(1 << INSADDR_WIDTH);

  loader_state_t state_r, state_nxt_s;

  logic                 cpu_rst_r, s_ready_r, busy_r, load_done_r;
  logic                 cpu_rst_nxt_s, s_ready_nxt_s, busy_nxt_s, load_done_nxt_s;
  logic [CNT_W-1:0]     target_r, wptr_r, loaded_count_r;
  logic [BCNT_W-1:0]    byte_cnt_r;
  logic [ASM_W-1:0]     asm_r;

  logic                 fire_s, last_byte_s, word_done_s, final_word_s;
  logic [ASM_W-1:0]     asm_nxt_s;
  logic [CNT_W-1:0]     wptr_inc_s, target_nxt_s;
  logic [8:0]           cnt_ext_s, tgt_s;
  logic                 unused_s;

  assign fire_s       = s_valid & s_ready_r;
  assign last_byte_s  = (byte_cnt_r == BCNT_W'(BYTES_PER_INS - 1));
  assign asm_nxt_s    = {asm_r[ASM_W-9:0], s_data};
  assign wptr_inc_s   = wptr_r + CNT_W'(1'b1);
  assign word_done_s  = (state_r == ST_DATA) & fire_s & last_byte_s;
  assign final_word_s = word_done_s & (wptr_inc_s == target_r);

  // Bits shifted out of the assembler and clamp headroom are intentionally dropped
  assign unused_s = ^{asm_r, asm_nxt_s, tgt_s};

  // Count byte to word target: zero means full depth, oversize clamps to depth
  always_comb begin
    cnt_ext_s = {1'b0, s_data};
    if ((cnt_ext_s == 9'd0) || (cnt_ext_s > DEPTH_9)) begin
      tgt_s = DEPTH_9;
    end else begin
      tgt_s = cnt_ext_s;
    end
    target_nxt_s = tgt_s[CNT_W-1:0];
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (fire_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      ST_DATA: begin
        // load_start is deliberately ignored while a load is in flight
        if (final_word_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    cpu_rst_nxt_s = 1'b1;
    s_ready_nxt_s = 1'b0;
    busy_nxt_s    = 1'b0;
    case (state_nxt_s)
      ST_COUNT, ST_DATA: begin
        s_ready_nxt_s = 1'b1;
        busy_nxt_s    = 1'b1;
      end
      ST_RUN: begin
        cpu_rst_nxt_s = 1'b0;
      end
      default: begin
        cpu_rst_nxt_s = 1'b1;
      end
    endcase

    load_done_nxt_s = (state_nxt_s == ST_RUN) && (state_r != ST_RUN);
  end

  // State register and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cpu_rst_r   <= 1'b1;
      s_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cpu_rst_r   <= cpu_rst_nxt_s;
      s_ready_r   <= s_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      load_done_r <= load_done_nxt_s;
    end
  end

  // Target capture, byte assembly, write pointer and completed-load count
  always_ff @(posedge clk) begin
    if (rst) begin
      target_r       <= {CNT_W{1'b0}};
      wptr_r         <= {CNT_W{1'b0}};
      byte_cnt_r     <= {BCNT_W{1'b0}};
      asm_r          <= {ASM_W{1'b0}};
      loaded_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_COUNT: begin
          if (fire_s) begin
            target_r   <= target_nxt_s;
            wptr_r     <= {CNT_W{1'b0}};
            byte_cnt_r <= {BCNT_W{1'b0}};
          end
        end
        ST_DATA: begin
          if (fire_s) begin
            asm_r <= asm_nxt_s;
            if (last_byte_s) begin
              // Pointer stops at target (<= depth), so it never wraps in a load
              wptr_r     <= wptr_inc_s;
              byte_cnt_r <= {BCNT_W{1'b0}};
            end else begin
              byte_cnt_r <= byte_cnt_r + BCNT_W'(1'b1);
            end
            if (final_word_s) begin
              loaded_count_r <= target_r;
            end
          end
        end
        default: begin
          wptr_r <= wptr_r;
        end
      endcase
    end
  end

  prog_loader_instr_mem #(
    .INS_WIDTH     (INS_WIDTH),
    .INSADDR_WIDTH (INSADDR_WIDTH)
  ) u_instr_mem (
    .clk   (clk),
    .we    (word_done_s),
    .waddr (wptr_r[INSADDR_WIDTH-1:0]),
    .wdata (asm_nxt_s[INS_WIDTH-1:0]),
    .raddr (instr_addr),
    .rdata (instr)
  );

  assign s_ready      = s_ready_r;
  assign cpu_rst      = cpu_rst_r;
  assign busy         = busy_r;
  assign load_done    = load_done_r;
  assign loaded_count = loaded_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed bench for prog_loader: a default instance (12-bit words, 256 deep)
// and a small instance (16 deep) for count clamping. Inputs change and outputs
// are sampled on the falling edge.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        load_start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  instr_addr = 8'h00;
  logic [11:0] instr;
  logic        cpu_rst, busy, load_done;
  logic [8:0]  loaded_count;

  logic        load_start2 = 1'b0;
  logic [7:0]  s_data2 = 8'h00;
  logic        s_valid2 = 1'b0;
  logic        s_ready2;
  logic [3:0]  instr_addr2 = 4'h0;
  logic [11:0] instr2;
  logic        cpu_rst2, busy2, load_done2;
  logic [4:0]  loaded_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_loader #(.INS_WIDTH(12), .INSADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .instr_addr(instr_addr),
    .instr(instr), .cpu_rst(cpu_rst), .busy(busy), .load_done(load_done),
    .loaded_count(loaded_count)
  );

  prog_loader #(.INS_WIDTH(12), .INSADDR_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .load_start(load_start2), .s_data(s_data2),
    .s_valid(s_valid2), .s_ready(s_ready2), .instr_addr(instr_addr2),
    .instr(instr2), .cpu_rst(cpu_rst2), .busy(busy2), .load_done(load_done2),
    .loaded_count(loaded_count2)
  );

  // Expected memory word from a big-endian byte pair (upper nibble dropped)
  function automatic logic [11:0] exp_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[3:0], lo};
  endfunction

  // Offer one byte; returns on the falling edge after the accepting rising edge
  task automatic send_byte(input bit sel, input logic [7:0] b);
    int tries;
    logic rdy;
    if (sel) begin s_data2 = b; s_valid2 = 1'b1; end
    else begin s_data = b; s_valid = 1'b1; end
    tries = 0;
    rdy = sel ? s_ready2 : s_ready;
    while (!rdy && tries < 16) begin
      @(negedge clk);
      tries++;
      rdy = sel ? s_ready2 : s_ready;
    end
    n_vec++;
    if (!rdy) begin
      n_err++;
      $display("FAIL send_timeout: s_ready got 0 after %0d cycles, expected 1", tries);
    end
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) load_start2 = 1'b1; else load_start = 1'b1;
    @(negedge clk);
    load_start  = 1'b0;
    load_start2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    load_start = 1'b1;  // rst must win over load_start
    repeat (2) @(negedge clk);
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    n_vec++; if (loaded_count !== 9'd0) begin n_err++; $display("FAIL reset_loaded_count: got %0d expected 0", loaded_count); end
    n_vec++; if (cpu_rst2 !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst_small: got %b expected 1", cpu_rst2); end
    rst = 1'b0;
    load_start = 1'b0;
    @(negedge clk);
    n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_beats_start: s_ready got %b expected 0", s_ready); end
  endtask

  task automatic test_basic_load;
    logic [7:0] st [7];
    st = '{8'h03, 8'h0A, 8'h05, 8'h01, 8'hFF, 8'hF2, 8'h34};
    pulse_start(1'b0);
    n_vec++; if (s_ready !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
      n_err++; $display("FAIL count_outputs: s_ready/busy/cpu_rst got %b%b%b expected 111", s_ready, busy, cpu_rst);
    end
    for (int i = 0; i < 7; i++) begin
      send_byte(1'b0, st[i]);
      if (i == 5) begin
        n_vec++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin
          n_err++; $display("FAIL basic_early_release: cpu_rst/busy got %b%b expected 11", cpu_rst, busy);
        end
      end
    end
    n_vec++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL basic_cpu_rst: got %b expected 0", cpu_rst); end
    n_vec++; if (busy !== 1'b0 || s_ready !== 1'b0) begin n_err++; $display("FAIL basic_run_outputs: busy/s_ready got %b%b expected 00", busy, s_ready); end
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL basic_load_done: got %b expected 1", load_done); end
    n_vec++; if (loaded_count !== 9'd3) begin n_err++; $display("FAIL basic_loaded_count: got %0d expected 3", loaded_count); end
    instr_addr = 8'd1; #1;
    n_vec++; if (instr !== 12'h1FF) begin n_err++; $display("FAIL basic_mem1: got %h expected 1ff", instr); end
    @(negedge clk);
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL basic_load_done_pulse: got %b expected 0", load_done); end
    n_vec++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL basic_cpu_rst_hold: got %b expected 0", cpu_rst); end
    instr_addr = 8'd0; #1;
    n_vec++; if (instr !== 12'hA05) begin n_err++; $display("FAIL basic_mem0: got %h expected a05", instr); end
    instr_addr = 8'd2; #1;
    n_vec++; if (instr !== 12'h234) begin n_err++; $display("FAIL basic_mem2: got %h expected 234", instr); end
  endtask

  task automatic test_full_depth;
    logic [7:0] hi, lo;
    int bad;
    pulse_start(1'b0);
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL full_cpu_rst_on_start: got %b expected 1", cpu_rst); end
    send_byte(1'b0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = ~8'(i);
      send_byte(1'b0, hi);
      if (i == 255) begin
        n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL full_early_release: cpu_rst got %b expected 1", cpu_rst); end
      end
      send_byte(1'b0, lo);
    end
    n_vec++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL full_cpu_rst: got %b expected 0", cpu_rst); end
    n_vec++; if (loaded_count !== 9'd256) begin n_err++; $display("FAIL full_loaded_count: got %0d expected 256", loaded_count); end
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL full_load_done: got %b expected 1", load_done); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      instr_addr = 8'(i); #1;
      n_vec++;
      if (instr !== exp_word(8'(i), ~8'(i))) begin
        n_err++;
        if (bad < 4) $display("FAIL full_mem[%0d]: got %h expected %h", i, instr, exp_word(8'(i), ~8'(i)));
        bad++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_gaps_and_ignored_start;
    logic [7:0] st [7];
    st = '{8'h03, 8'h0A, 8'h05, 8'h01, 8'hFF, 8'hF2, 8'h34};
    pulse_start(1'b0);
    for (int i = 0; i < 7; i++) begin
      int gaps;
      gaps = 0;
      // Guaranteed gap before the last byte, random (30%) gaps elsewhere
      while ((i == 6 && gaps == 0) || ($urandom_range(0, 9) < 3 && gaps < 3)) begin
        if (i == 3 && gaps == 0) load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        gaps++;
        n_vec++; if (s_ready !== 1'b1 || cpu_rst !== 1'b1) begin
          n_err++; $display("FAIL gap_outputs byte %0d: s_ready/cpu_rst got %b%b expected 11", i, s_ready, cpu_rst);
        end
      end
      if (i == 3 && gaps == 0) begin
        // No random gap here: pulse load_start for one DATA cycle anyway
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL gap_start_ignored: s_ready got %b expected 1", s_ready); end
      end
      send_byte(1'b0, st[i]);
    end
    n_vec++; if (cpu_rst !== 1'b0 || load_done !== 1'b1) begin
      n_err++; $display("FAIL gap_release: cpu_rst/load_done got %b%b expected 01", cpu_rst, load_done);
    end
    n_vec++; if (loaded_count !== 9'd3) begin n_err++; $display("FAIL gap_loaded_count: got %0d expected 3", loaded_count); end
    instr_addr = 8'd0; #1;
    n_vec++; if (instr !== 12'hA05) begin n_err++; $display("FAIL gap_mem0: got %h expected a05", instr); end
    instr_addr = 8'd1; #1;
    n_vec++; if (instr !== 12'h1FF) begin n_err++; $display("FAIL gap_mem1: got %h expected 1ff", instr); end
    instr_addr = 8'd2; #1;
    n_vec++; if (instr !== 12'h234) begin n_err++; $display("FAIL gap_mem2: got %h expected 234", instr); end
    instr_addr = 8'd3; #1;
    n_vec++; if (instr !== 12'h3FC) begin n_err++; $display("FAIL gap_mem3_kept: got %h expected 3fc", instr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    pulse_start(1'b0);
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h0B);
    send_byte(1'b0, 8'hCD);
    send_byte(1'b0, 8'h06);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (cpu_rst !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs: cpu_rst/s_ready/busy got %b%b%b expected 100", cpu_rst, s_ready, busy);
    end
    n_vec++; if (loaded_count !== 9'd0) begin n_err++; $display("FAIL midrst_loaded_count: got %0d expected 0", loaded_count); end
    instr_addr = 8'd0; #1;
    n_vec++; if (instr !== 12'hBCD) begin n_err++; $display("FAIL midrst_mem0: got %h expected bcd", instr); end
    instr_addr = 8'd1; #1;
    n_vec++; if (instr !== 12'h1FF) begin n_err++; $display("FAIL midrst_mem1: got %h expected 1ff", instr); end
    @(negedge clk);
    pulse_start(1'b0);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h0C);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h0D);
    send_byte(1'b0, 8'h22);
    n_vec++; if (cpu_rst !== 1'b0 || loaded_count !== 9'd2) begin
      n_err++; $display("FAIL fresh_done: cpu_rst=%b loaded_count=%0d expected 0 and 2", cpu_rst, loaded_count);
    end
    instr_addr = 8'd0; #1;
    n_vec++; if (instr !== 12'hC11) begin n_err++; $display("FAIL fresh_mem0: got %h expected c11", instr); end
    instr_addr = 8'd1; #1;
    n_vec++; if (instr !== 12'hD22) begin n_err++; $display("FAIL fresh_mem1: got %h expected d22", instr); end
    instr_addr = 8'd2; #1;
    n_vec++; if (instr !== 12'h234) begin n_err++; $display("FAIL fresh_mem2_kept: got %h expected 234", instr); end
    @(negedge clk);
  endtask

  task automatic test_reload_from_run;
    pulse_start(1'b0);
    n_vec++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL reload_reassert: cpu_rst/busy got %b%b expected 11", cpu_rst, busy);
    end
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h07);
    n_vec++; if (cpu_rst !== 1'b0 || loaded_count !== 9'd1) begin
      n_err++; $display("FAIL reload_done: cpu_rst=%b loaded_count=%0d expected 0 and 1", cpu_rst, loaded_count);
    end
    instr_addr = 8'd0; #1;
    n_vec++; if (instr !== 12'h007) begin n_err++; $display("FAIL reload_mem0: got %h expected 007", instr); end
    instr_addr = 8'd1; #1;
    n_vec++; if (instr !== 12'hD22) begin n_err++; $display("FAIL reload_mem1_kept: got %h expected d22", instr); end
    instr_addr = 8'd2; #1;
    n_vec++; if (instr !== 12'h234) begin n_err++; $display("FAIL reload_mem2_kept: got %h expected 234", instr); end
    @(negedge clk);
  endtask

  task automatic test_clamp_small;
    pulse_start(1'b1);
    send_byte(1'b1, 8'h20);
    for (int i = 0; i < 16; i++) begin
      send_byte(1'b1, 8'hA0 | 8'(i));
      if (i == 15) begin
        n_vec++; if (cpu_rst2 !== 1'b1) begin n_err++; $display("FAIL clamp_early_release: cpu_rst got %b expected 1", cpu_rst2); end
      end
      send_byte(1'b1, 8'(i * 7));
    end
    n_vec++; if (cpu_rst2 !== 1'b0 || s_ready2 !== 1'b0) begin
      n_err++; $display("FAIL clamp_release: cpu_rst/s_ready got %b%b expected 00", cpu_rst2, s_ready2);
    end
    n_vec++; if (loaded_count2 !== 5'd16) begin n_err++; $display("FAIL clamp_loaded_count: got %0d expected 16", loaded_count2); end
    n_vec++; if (load_done2 !== 1'b1) begin n_err++; $display("FAIL clamp_load_done: got %b expected 1", load_done2); end
    instr_addr2 = 4'd0; #1;
    n_vec++; if (instr2 !== 12'h000) begin n_err++; $display("FAIL clamp_mem0: got %h expected 000", instr2); end
    instr_addr2 = 4'd7; #1;
    n_vec++; if (instr2 !== 12'h731) begin n_err++; $display("FAIL clamp_mem7: got %h expected 731", instr2); end
    instr_addr2 = 4'd15; #1;
    n_vec++; if (instr2 !== 12'hF69) begin n_err++; $display("FAIL clamp_mem15: got %h expected f69", instr2); end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_full_depth();
    test_gaps_and_ignored_start();
    test_reset_mid_load();
    test_reload_from_run();
    test_clamp_small();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
